// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    logic              r_main_v;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_main_v_next;
    logic              w_skid_v_next;
    logic [DATA_W-1:0] w_main_data_next;
    logic [CTRL_W-1:0] w_main_ctrl_next;
    logic [DATA_W-1:0] w_skid_data_next;
    logic [CTRL_W-1:0] w_skid_ctrl_next;
    logic              w_in_fire;
    logic              w_out_fire;

    // With the skid buffer, in_ready is a pure register output so the
    // upstream timing path never sees out_ready.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !r_skid_v;
        end else begin : g_noskid
            assign in_ready = !r_main_v | out_ready;
        end
    endgenerate

    assign w_in_fire  = in_valid & in_ready & !FLUSH;
    assign w_out_fire = r_main_v & out_ready;

    always_comb begin
        w_main_v_next    = r_main_v;
        w_skid_v_next    = r_skid_v;
        w_main_data_next = r_main_data;
        w_main_ctrl_next = r_main_ctrl;
        w_skid_data_next = r_skid_data;
        w_skid_ctrl_next = r_skid_ctrl;
        if (w_out_fire) begin
            if (r_skid_v) begin
                // Older skid beat must leave before anything newer.
                w_main_data_next = r_skid_data;
                w_main_ctrl_next = r_skid_ctrl;
                w_skid_v_next    = 1'b0;
                w_skid_data_next = '0;
                w_skid_ctrl_next = '0;
            end else if (w_in_fire) begin
                w_main_data_next = in_data;
                w_main_ctrl_next = in_ctrl;
            end else begin
                w_main_v_next    = 1'b0;
                w_main_data_next = '0;
                w_main_ctrl_next = '0;
            end
        end else if (w_in_fire) begin
            if (!r_main_v) begin
                w_main_v_next    = 1'b1;
                w_main_data_next = in_data;
                w_main_ctrl_next = in_ctrl;
            end else if (SKID != 0) begin
                w_skid_v_next    = 1'b1;
                w_skid_data_next = in_data;
                w_skid_ctrl_next = in_ctrl;
            end
        end
        if (FLUSH) begin
            w_main_v_next    = 1'b0;
            w_skid_v_next    = 1'b0;
            w_main_data_next = '0;
            w_main_ctrl_next = '0;
            w_skid_data_next = '0;
            w_skid_ctrl_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_main_v     <= 1'b0;
            r_skid_v     <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_main_v    <= w_main_v_next;
            r_skid_v    <= w_skid_v_next;
            r_main_data <= w_main_data_next;
            r_main_ctrl <= w_main_ctrl_next;
            r_skid_data <= w_skid_data_next;
            r_skid_ctrl <= w_skid_ctrl_next;
            if (r_main_v && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!r_main_v && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    // Invalid beats never expose stale control bits downstream.
    assign out_valid  = r_main_v;
    assign out_data   = r_main_v ? r_main_data : '0;
    assign out_ctrl   = r_main_v ? r_main_ctrl : '0;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (4-bit counters) and a no-skid instance,
// driven from vector tables and hand sequences, checked against a queue model.
module tb_pipe_stage_reg;
    logic        clk;
    logic        clr;
    // skid instance (SKID=1, CNT_W=4)
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [5:0]  s_in_ctrl, s_out_ctrl;
    logic [3:0]  s_stall, s_bubble;
    // no-skid instance (SKID=0, CNT_W=16)
    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [5:0]  n_in_ctrl, n_out_ctrl;
    logic [15:0] n_stall, n_bubble;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [37:0] q0[$];
    logic [37:0] q1[$];
    int stall_m[2];
    int bubble_m[2];
    int cmax[2];

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
    } vec_t;

    vec_t tbl_s[$];
    vec_t tbl_n[$];

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(1), .CNT_W(4)) u_skid (
        .CLK(clk), .CLR(clr), .FLUSH(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_cnt(s_stall), .bubble_cnt(s_bubble)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(6), .SKID(0), .CNT_W(16)) u_noskid (
        .CLK(clk), .CLR(clr), .FLUSH(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .stall_cnt(n_stall), .bubble_cnt(n_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ctrl_of(input logic [31:0] d);
        return d[5:0] ^ 6'h15;
    endfunction

    function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                                input logic e_ov, input logic [31:0] e_od, input logic e_ir);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL dut%0d %s cycle %0d: got %0h expected %0h", k, nm, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_out_ready = 1'b1;
        n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_in_ctrl = '0; n_out_ready = 1'b1;
    endtask

    task automatic reset_model();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            stall_m[k]  = 0;
            bubble_m[k] = 0;
        end
    endtask

    // Compare one instance against the model, then advance the model by this cycle.
    task automatic eval_dut(input int k);
        logic        a_ov, a_ir, fl, iv, ordy, m_ov, m_ir, o_fire, i_fire;
        logic [31:0] a_od, d, a_st, a_bu, e_od;
        logic [5:0]  a_oc, c, e_oc;
        logic [37:0] front;
        int          sz;
        if (k == 0) begin
            a_ov = s_out_valid; a_ir = s_in_ready; a_od = s_out_data; a_oc = s_out_ctrl;
            a_st = 32'(s_stall); a_bu = 32'(s_bubble);
            fl = s_flush; iv = s_in_valid; d = s_in_data; c = s_in_ctrl; ordy = s_out_ready;
            sz = q0.size();
            front = (sz > 0) ? q0[0] : '0;
        end else begin
            a_ov = n_out_valid; a_ir = n_in_ready; a_od = n_out_data; a_oc = n_out_ctrl;
            a_st = 32'(n_stall); a_bu = 32'(n_bubble);
            fl = n_flush; iv = n_in_valid; d = n_in_data; c = n_in_ctrl; ordy = n_out_ready;
            sz = q1.size();
            front = (sz > 0) ? q1[0] : '0;
        end
        m_ov = (sz > 0);
        m_ir = (k == 0) ? (sz < 2) : ((sz == 0) || ordy);
        e_od = m_ov ? front[31:0] : 32'h0;
        e_oc = m_ov ? front[37:32] : 6'h0;
        chk(k, "out_valid", 32'(a_ov), 32'(m_ov));
        chk(k, "in_ready", 32'(a_ir), 32'(m_ir));
        chk(k, "out_data", a_od, e_od);
        chk(k, "out_ctrl", 32'(a_oc), 32'(e_oc));
        chk(k, "stall_cnt", a_st, 32'(stall_m[k]));
        chk(k, "bubble_cnt", a_bu, 32'(bubble_m[k]));
        o_fire = m_ov & ordy;
        i_fire = iv & m_ir & !fl;
        if (o_fire) begin
            $display("dut%0d cycle %0d: beat out data=%h ctrl=%h", k, cyc, e_od, e_oc);
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (fl) begin
            if (k == 0) q0.delete(); else q1.delete();
        end else if (i_fire) begin
            if (k == 0) q0.push_back({c, d}); else q1.push_back({c, d});
        end
        if (m_ov && !ordy && (stall_m[k] != cmax[k])) stall_m[k]++;
        if (!m_ov && (bubble_m[k] != cmax[k])) bubble_m[k]++;
    endtask

    // Drive one cycle on instance sel (other instance idles); entered and left at posedge+1.
    task automatic cycle(input int sel, input logic fl, input logic iv, input logic [31:0] d,
                         input logic ordy, input logic has_exp, input logic e_ov,
                         input logic [31:0] e_od, input logic e_ir);
        idle_inputs();
        if (sel == 0) begin
            s_flush = fl; s_in_valid = iv; s_in_data = d; s_in_ctrl = ctrl_of(d); s_out_ready = ordy;
        end else begin
            n_flush = fl; n_in_valid = iv; n_in_data = d; n_in_ctrl = ctrl_of(d); n_out_ready = ordy;
        end
        @(negedge clk);
        if (has_exp) begin
            if (sel == 0) begin
                chk(0, "tbl_out_valid", 32'(s_out_valid), 32'(e_ov));
                chk(0, "tbl_out_data", s_out_data, e_od);
                chk(0, "tbl_in_ready", 32'(s_in_ready), 32'(e_ir));
            end else begin
                chk(1, "tbl_out_valid", 32'(n_out_valid), 32'(e_ov));
                chk(1, "tbl_out_data", n_out_data, e_od);
                chk(1, "tbl_in_ready", 32'(n_in_ready), 32'(e_ir));
            end
        end
        eval_dut(0);
        eval_dut(1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_clr(input int n);
        clr = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_flush = 1'($urandom_range(0, 1)); s_in_valid = 1'b1; s_in_data = $urandom;
            s_in_ctrl = 6'($urandom); s_out_ready = 1'($urandom_range(0, 1));
            n_flush = 1'b0; n_in_valid = 1'b1; n_in_data = $urandom;
            n_in_ctrl = 6'($urandom); n_out_ready = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                chk(0, "clr_out_valid", 32'(s_out_valid), 32'h0);
                chk(0, "clr_out_data", s_out_data, 32'h0);
                chk(0, "clr_out_ctrl", 32'(s_out_ctrl), 32'h0);
                chk(0, "clr_stall", 32'(s_stall), 32'h0);
                chk(0, "clr_bubble", 32'(s_bubble), 32'h0);
                chk(1, "clr_out_valid", 32'(n_out_valid), 32'h0);
                chk(1, "clr_out_ctrl", 32'(n_out_ctrl), 32'h0);
                chk(1, "clr_stall", 32'(n_stall), 32'h0);
                chk(1, "clr_bubble", 32'(n_bubble), 32'h0);
                chk(1, "clr_in_ready", 32'(n_in_ready), 32'h1);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        clr = 1'b0;
        idle_inputs();
        reset_model();
    endtask

    initial begin
        cmax[0] = 15;
        cmax[1] = 65535;
        clr = 1'b1;
        idle_inputs();
        reset_model();

        //        fl    iv    data       ordy  e_ov  e_od       e_ir
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h11, 1'b1, 1'b1, 32'h10, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h12, 1'b1, 1'b1, 32'h11, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h13, 1'b1, 1'b1, 32'h12, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h13, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hA,  1'b0, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  1'b0));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  1'b0));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 32'hA,  1'b0));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hC,  1'b1, 1'b1, 32'hB,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hA,  1'b0, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'hB,  1'b0, 1'b1, 32'hA,  1'b1));
        tbl_s.push_back(mk(1'b1, 1'b1, 32'hC,  1'b0, 1'b1, 32'hA,  1'b0));
        tbl_s.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b1, 1'b1, 32'h21, 1'b1, 1'b1, 32'h20, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 32'h0,  1'b1));
        tbl_s.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h22, 1'b1));
        tbl_s.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1));

        tbl_n.push_back(mk(1'b0, 1'b1, 32'h54, 1'b0, 1'b0, 32'h0,  1'b1));
        tbl_n.push_back(mk(1'b0, 1'b1, 32'h55, 1'b0, 1'b1, 32'h54, 1'b0));
        tbl_n.push_back(mk(1'b0, 1'b1, 32'h55, 1'b1, 1'b1, 32'h54, 1'b1));
        tbl_n.push_back(mk(1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h55, 1'b0));
        tbl_n.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 1'b1));
        tbl_n.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1));
        tbl_n.push_back(mk(1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  1'b1));
        tbl_n.push_back(mk(1'b1, 1'b1, 32'h61, 1'b1, 1'b1, 32'h60, 1'b1));
        tbl_n.push_back(mk(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1));

        do_clr(2);
        foreach (tbl_s[i])
            cycle(0, tbl_s[i].fl, tbl_s[i].iv, tbl_s[i].d, tbl_s[i].ordy, 1'b1,
                  tbl_s[i].e_ov, tbl_s[i].e_od, tbl_s[i].e_ir);

        do_clr(2);
        foreach (tbl_n[i])
            cycle(1, tbl_n[i].fl, tbl_n[i].iv, tbl_n[i].d, tbl_n[i].ordy, 1'b1,
                  tbl_n[i].e_ov, tbl_n[i].e_od, tbl_n[i].e_ir);

        // Stall counter saturation: one beat held for 20 cycles.
        do_clr(2);
        cycle(0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk(0, "stall_sat", 32'(s_stall), 32'd15);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Bubble counter saturation, then CLR returns it to zero.
        do_clr(2);
        for (int i = 0; i < 20; i++) cycle(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk(0, "bubble_sat", 32'(s_bubble), 32'd15);
        do_clr(2);
        chk(0, "bubble_after_clr", 32'(s_bubble), 32'd0);
        cycle(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-field inter-stage latches (ID/EX, EX/MEM, MEM/WB) in the 5-stage MIPS pipeline.
- Adds a valid/ready handshake, an optional 2-entry skid buffer, a synchronous flush, and saturating stall/bubble counters.
- Carries a datapath payload and a control-bit vector.
- Invalid beats always present all-zero control, so an invalid beat can never cause RegWrite or MemWrite side effects.

Parameters:
DATA_W, 32, width of the datapath payload (ALU result, operands, PC, instruction concatenated by the instantiator)
CTRL_W, 6, width of the control-bit vector (JAL, MemToReg, RegWrite, MemWrite, HalfW, Syscall, ...)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of each performance counter

Ports:
CLK  in  1  clock, rising edge
CLR  in  1  reset, synchronous, active-high
FLUSH  in  1  synchronous squash of all held beats and of the beat presented this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
out_valid  out  1  held beat valid (equivalent of the Eff flag)
out_ready  in  1  downstream accepts the beat
out_data  out  DATA_W  payload; all zero when out_valid=0
out_ctrl  out  CTRL_W  control bits; all zero when out_valid=0
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating

Behaviour:
- Definitions: in_fire = in_valid & in_ready & !FLUSH. out_fire = out_valid & out_ready.
- Priority: CLR > FLUSH > normal operation.
- CLR (sampled at the clock edge):
  - main and skid entries invalid, all payload/ctrl registers zero.
  - out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, bubble_cnt=0.
  - in_ready=1 on the cycle after CLR deasserts; in_ready=1 during CLR for SKID=0.
- FLUSH:
  - Next cycle: main and skid invalid, their registers zero.
  - The beat presented in the FLUSH cycle is discarded.
  - Counters are not cleared and count normally.
  - out_fire in the FLUSH cycle is still a legal transfer downstream.
- Latency: accepted beat appears on out_* on the next cycle. Sustained throughput is 1 beat per cycle while out_ready=1.
- SKID=1, state = {main_v, skid_v}, with skid_v implying main_v:
  - EMPTY {0,0}: in_fire -> main, go to ONE.
  - ONE {1,0}:
    - out_fire & in_fire -> main replaced, stay ONE.
    - out_fire & !in_fire -> EMPTY.
    - !out_fire & in_fire -> beat into skid, go to FULL.
  - FULL {1,1}:
    - out_fire -> skid moves to main, go to ONE.
    - otherwise hold.
  - in_ready = !skid_v, registered; it never depends combinationally on out_ready.
  - In FULL, in_fire is impossible because in_ready=0. A beat offered anyway is ignored; upstream must hold it.
  - Order is preserved: the skid beat always leaves before any newer beat.
- SKID=0: single main register. in_ready = !main_v | out_ready (combinational). in_fire loads main; out_fire without in_fire clears main_v.
- Zeroing:
  - When a beat leaves (out_fire) and nothing replaces it, main data/ctrl registers load zero.
  - out_data/out_ctrl are additionally gated to zero whenever out_valid=0.
- Counters:
  - Increment by 1 per qualifying cycle and stick at 2^CNT_W-1; no wrap.
  - Neither counter counts during a CLR cycle.
- Holding: out_data/out_ctrl are stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset values: drive junk on all inputs with CLR=1 for 2 cycles, then release -> out_valid=0, out_data=0, out_ctrl=0, both counters 0; in_ready=1 the cycle after release.
2. Streaming: in_valid=1 with in_data=0x10,0x11,0x12,0x13 on consecutive cycles, out_ready=1 -> out_data=0x10..0x13 on cycles 1..4, no gaps; stall_cnt stays 0.
3. Backpressure (SKID=1): send 0xA then 0xB while out_ready=0 -> in_ready drops to 0 after 0xB is taken; 0xC is held upstream; stall_cnt counts stall cycles. Raise out_ready -> output order is 0xA, 0xB, 0xC with none lost.
4. Flush mid-stall: state FULL with {0xA,0xB}, FLUSH=1 while in_valid=1 carrying 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xC is never output; the counters keep their values.
5. Saturation (CNT_W=4): hold out_valid=0 for 20 cycles -> bubble_cnt reaches 15 and stays at 15; CLR returns it to 0.
6. SKID=0: out_valid=1, out_ready toggled -> in_ready equals out_ready in the same cycle; 0x55 accepted in the same cycle 0x54 leaves appears on the next cycle.
